// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: opcodes, PC-select encodings and FSM states shared by the redirect unit
package pc_redirect_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [1:0] PC_BRANCH  = 2'b00;
    localparam logic [1:0] PC_REG     = 2'b01;
    localparam logic [1:0] PC_INDEX   = 2'b10;
    localparam logic [1:0] PC_TRAP    = 2'b11;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0040;
    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
    function automatic logic legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                          6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction
endpackage

// File: rtl/pc_redirect_branch_decode.sv
// branch_decode: combinational map of instruction/nextpc/operands to redirect, type and target
module branch_decode
    import pc_redirect_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] i_instruc,
    input  logic [31:0] i_nextpc,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic        o_redirect,
    output logic [1:0]  o_type,
    output logic [31:0] o_target
);
    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    assign w_op         = i_instruc[31:26];
    assign w_fn         = i_instruc[5:0];
    assign w_br_target  = i_nextpc + {{14{i_instruc[15]}}, i_instruc[15:0], 2'b00};
    assign w_jmp_target = {i_nextpc[31:28], i_instruc[25:0], 2'b00};
    always_comb begin
        o_redirect = 1'b0;
        o_type     = PC_BRANCH;
        o_target   = w_br_target;
        if (w_op == OP_BEQ || w_op == OP_BNE)
            o_redirect = (i_rs_data == i_rt_data) ^ (w_op == OP_BNE);
        else if (w_op == OP_J || w_op == OP_JAL) begin
            o_redirect = 1'b1;
            o_type     = PC_INDEX;
            o_target   = w_jmp_target;
        end else if (w_op == OP_SPECIAL && (w_fn == FN_JR || w_fn == FN_JALR)) begin
            o_redirect = 1'b1;
            o_type     = PC_REG;
            o_target   = i_rs_data;
        end else if ((w_op == OP_SPECIAL && w_fn == FN_SYSCALL) || !legal_op(w_op)) begin
            o_redirect = 1'b1;
            o_type     = PC_TRAP;
            o_target   = EXC_VECTOR;
        end
    end
endmodule

// File: rtl/pc_redirect.sv
// pc_redirect: decode-side redirect sequencer (redirect, delay slot, one squashed wrong-path word)
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_if_stall,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    output logic [4:0]  rf_rs_addr,
    output logic [4:0]  rf_rt_addr,
    input  logic [31:0] rf_rs_data,
    input  logic [31:0] rf_rt_data,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_ex_instruc,
    output logic [31:0] id_ex_nextpc,
    output logic        id_ex_valid
);
    state_t      r_state, w_state;
    logic        r_sel, w_sel, r_val, w_val;
    logic [1:0]  r_type, w_type;
    logic [31:0] r_imd, w_imd, r_rega, w_rega, r_idx, w_idx;
    logic [31:0] r_ins, w_ins, r_npc, w_npc;
    logic        w_redirect;
    logic [1:0]  w_dec_type;
    logic [31:0] w_dec_target;
    assign rf_rs_addr = if_id_instruc[25:21];
    assign rf_rt_addr = if_id_instruc[20:16];
    branch_decode #(.EXC_VECTOR(EXC_VECTOR)) u_dec (
        .i_instruc (if_id_instruc),
        .i_nextpc  (if_id_nextpc),
        .i_rs_data (rf_rs_data),
        .i_rt_data (rf_rt_data),
        .o_redirect(w_redirect),
        .o_type    (w_dec_type),
        .o_target  (w_dec_target)
    );
    always_comb begin
        w_state = r_state;
        w_sel   = r_sel;
        w_type  = r_type;
        w_imd   = r_imd;
        w_rega  = r_rega;
        w_idx   = r_idx;
        w_npc   = r_npc;
        w_ins   = '0;
        w_val   = 1'b0;
        if (!ex_if_stall) begin
            w_npc = if_id_nextpc;
            w_ins = (r_state == SQUASH) ? '0 : if_id_instruc;
            w_val = (r_state != SQUASH) && (if_id_instruc != '0);
            case (r_state)
                IDLE: if (w_redirect) begin
                    w_state = REDIRECT;
                    w_sel   = 1'b1;
                    w_type  = w_dec_type;
                    w_imd   = (w_dec_type == PC_BRANCH) ? w_dec_target : r_imd;
                    w_rega  = (w_dec_type == PC_REG)    ? w_dec_target : r_rega;
                    w_idx   = (w_dec_type == PC_INDEX)  ? w_dec_target : r_idx;
                end
                REDIRECT: begin
                    w_state = SQUASH;
                    w_sel   = 1'b0;
                end
                default: w_state = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_type  <= PC_BRANCH;
            r_imd   <= '0;
            r_rega  <= '0;
            r_idx   <= '0;
            r_ins   <= '0;
            r_npc   <= '0;
            r_val   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sel   <= w_sel;
            r_type  <= w_type;
            r_imd   <= w_imd;
            r_rega  <= w_rega;
            r_idx   <= w_idx;
            r_ins   <= w_ins;
            r_npc   <= w_npc;
            r_val   <= w_val;
        end
    end
    assign id_if_selpcsource = r_sel;
    assign id_if_selpctype   = r_type;
    assign id_if_pcimd2ext   = r_imd;
    assign id_if_rega        = r_rega;
    assign id_if_pcindex     = r_idx;
    assign id_ex_instruc     = r_ins;
    assign id_ex_nextpc      = r_npc;
    assign id_ex_valid       = r_val;
endmodule
